// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame-format constants
// common to the receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, synchronous, first-word fall-through. dout shows the head
// entry and reads as zero while empty. A push into a full FIFO is only
// accepted when a pop happens in the same clock; a pop of an empty FIFO is
// ignored.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: unwritten entries are masked by empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_control.sv
// UART receiver: synchronises rxd, frames 8N1 characters on baud_en ticks,
// pushes good bytes into the receive FIFO and keeps sticky error flags.
module uart_rx_control
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int DEPTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_en,
    input  logic                 rxd,
    input  logic                 fifo_read,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 overrun,
    output logic                 framing_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [1:0]           sync;
    logic                 rxs;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;

    logic tcnt_clr, tcnt_inc, bcnt_clr, bcnt_inc, shift_en, stop_sample;
    logic push, framing_set, overrun_set;
    logic fifo_empty, fifo_full;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rxd};
    end
    assign rxs = sync[1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; everything advances only on baud_en ticks.
    always_comb begin
        state_next = state;
        if (baud_en) begin
            case (state)
                RX_IDLE:  if (!rxs) state_next = RX_START;
                RX_START: if (tcnt == T_HALF) state_next = rxs ? RX_IDLE : RX_DATA;
                RX_DATA:  if (tcnt == T_FULL && bcnt == B_LAST) state_next = RX_STOP;
                RX_STOP:  if (tcnt == T_FULL) state_next = RX_IDLE;
                default:  state_next = RX_IDLE;
            endcase
        end
    end

    // FSM outputs: counter control, shift strobe and the mid-stop sample.
    always_comb begin
        tcnt_clr    = 1'b0;
        tcnt_inc    = 1'b0;
        bcnt_clr    = 1'b0;
        bcnt_inc    = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
        if (baud_en) begin
            case (state)
                RX_IDLE: tcnt_clr = 1'b1;
                RX_START: begin
                    if (tcnt == T_HALF) begin
                        tcnt_clr = 1'b1;
                        bcnt_clr = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tcnt == T_FULL) begin
                        tcnt_clr = 1'b1;
                        shift_en = 1'b1;
                        bcnt_inc = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tcnt == T_FULL) begin
                        stop_sample = 1'b1;
                        tcnt_clr    = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
                default: tcnt_clr = 1'b1;
            endcase
        end
    end

    // Good stop bit pushes; a full FIFO with no pop in the same clock drops
    // the byte as an overrun. A low stop bit only raises framing_err.
    assign push        = stop_sample && rxs;
    assign framing_set = stop_sample && !rxs;
    assign overrun_set = push && fifo_full && !fifo_read;

    // Tick counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            if (tcnt_clr)      tcnt <= '0;
            else if (tcnt_inc) tcnt <= tcnt + TW'(1);
            if (bcnt_clr)      bcnt <= '0;
            else if (bcnt_inc) bcnt <= bcnt + BW'(1);
            if (shift_en)      shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (overrun_set)      overrun <= 1'b1;
            else if (clr_err)     overrun <= 1'b0;
            if (framing_set)      framing_err <= 1'b1;
            else if (clr_err)     framing_err <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fifo_read),
        .din   (shreg),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rda = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_control.sv
// Directed bench for uart_rx_control: baud_en every 4 clks, 16x oversample,
// so one bit period is 64 clks. Inputs change on the falling edge.
module tb_uart_rx_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_en = 1'b0;
    logic       rxd = 1'b1;
    logic       fifo_read = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       overrun;
    logic       framing_err;

    int n_checks = 0;
    int n_pass   = 0;
    int div      = 0;
    int rise_off = 0;
    int rise_tick = 0;
    logic prev_baud = 1'b0;

    uart_rx_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_en     (baud_en),
        .rxd         (rxd),
        .fifo_read   (fifo_read),
        .clr_err     (clr_err),
        .rx_data     (rx_data),
        .rda         (rda),
        .overrun     (overrun),
        .framing_err (framing_err)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    // baud_en: one-clk pulse every 4 clks, updated just after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            baud_en = (div == 0);
        end
    end

    // baud_en value seen by the most recent rising edge
    always @(posedge clk) prev_baud <= baud_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pop_pulse();
        fifo_read = 1'b1;
        @(negedge clk);
        fifo_read = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Drive one frame. The push clk falls 35..38 clks into the stop bit
    // (2-clk synchroniser, start detect on the next tick, 152 ticks to mid-stop).
    // pop_on_push asserts fifo_read for exactly the tick clk in that window.
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic pop_on_push);
        logic rda_was;
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (64) @(negedge clk);
        end
        rxd = stop;
        rda_was = rda;
        rise_off = 0;
        rise_tick = 0;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (rda && !rda_was && rise_off == 0) begin
                rise_off = j;
                rise_tick = int'(prev_baud);
            end
            rda_was = rda;
            fifo_read = pop_on_push && baud_en && (j + 1 >= 35) && (j + 1 <= 38);
        end
        fifo_read = 1'b0;
        rxd = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rda", rda, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ovr", overrun, 0);
        check("rst_frm", framing_err, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // 1. Frame 0xA5
        send_byte(8'hA5, 1'b1, 1'b0);
        check("t1_rise_win", (rise_off >= 35 && rise_off <= 38), 1);
        check("t1_rise_tick", rise_tick, 1);
        check("t1_rda", rda, 1);
        check("t1_data", rx_data, 8'hA5);
        check("t1_frm", framing_err, 0);
        check("t1_ovr", overrun, 0);
        pop_pulse();
        check("t1_rda_pop", rda, 0);
        check("t1_data_pop", rx_data, 8'h00);
        repeat (20) @(negedge clk);

        // 2. Short low glitch rejected in START
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("t2_rda", rda, 0);
        check("t2_frm", framing_err, 0);
        check("t2_ovr", overrun, 0);

        // 3. Framing error on 0x3C, then clear
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        check("t3_frm", framing_err, 1);
        check("t3_rda", rda, 0);
        check("t3_ovr", overrun, 0);
        clr_pulse();
        check("t3_frm_clr", framing_err, 0);

        // 4. Nine back-to-back frames, no reads: ninth overruns
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_ovr", overrun, 1);
        check("t4_rda", rda, 1);
        check("t4_frm", framing_err, 0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t4_rd%0d", i), rx_data, 32'(i));
            pop_pulse();
        end
        check("t4_empty", rda, 0);
        clr_pulse();
        check("t4_ovr_clr", overrun, 0);

        // 5. Full FIFO, pop on the push clk of 0x55
        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), 1'b1, 1'b0);
        check("t5_full_ovr", overrun, 0);
        check("t5_head0", rx_data, 8'h60);
        send_byte(8'h55, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t5_ovr", overrun, 0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t5_rd%0d", i), rx_data, 32'(8'h60 + i));
            pop_pulse();
        end
        check("t5_tail", rx_data, 8'h55);
        pop_pulse();
        check("t5_empty", rda, 0);

        // 6. Reset mid-frame, then a clean frame
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        check("t6_pre_rda", rda, 1);
        check("t6_pre_frm", framing_err, 1);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_rda", rda, 0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_ovr", overrun, 0);
        check("t6_rst_frm", framing_err, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        send_byte(8'h12, 1'b1, 1'b0);
        check("t6_rda", rda, 1);
        check("t6_data", rx_data, 8'h12);
        check("t6_frm", framing_err, 0);
        pop_pulse();
        check("t6_empty", rda, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
